prefetch_fetcher: RTL and testbench

Parametrised instruction fetcher with a prefetch FIFO and a PC-redirect flush. It sits between a core's scheduler/decoder and the program-memory controller, so fetch latency is hidden when consecutive PCs are sequential. It issues one program-memory read at a time and keeps running ahead of the consumer until the FIFO is full. On redirect it flushes everything and restarts at the new PC.

---
 rtl/prefetch_fetcher.sv | 191 +++++++++++++++++++
 tb/tb_prefetch_fetcher.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_fetcher.sv
// -----------------------------------------------------------------------------
// prefetch_fetcher
//
// Instruction fetcher with a small prefetch FIFO. It sits between the core's
// decoder and the program-memory controller and keeps one read in flight at a
// time, running ahead of the consumer until the FIFO is full. A redirect
// flushes the FIFO and restarts fetching at a new PC.
//
// Parameters
//   PROGRAM_MEM_ADDR_BITS  program address width (also the PC width)
//   PROGRAM_MEM_DATA_BITS  instruction width
//   FIFO_DEPTH             prefetch entries (power of two, >= 2)
//
// Ports
//   clk               clock, rising edge
//   reset             asynchronous active-high reset
//   redirect          one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc       new fetch PC, sampled while redirect is high
//   mem_read_valid    registered read request to program memory
//   mem_read_address  registered read address
//   mem_read_ready    memory completes the request this cycle
//   mem_read_data     returned instruction, valid with mem_read_ready
//   instr_valid       FIFO head is valid
//   instruction       FIFO head instruction (0 when instr_valid is low)
//   instr_pc          PC of the FIFO head (0 when instr_valid is low)
//   instr_ready       consumer pops the head when instr_valid is also high
// -----------------------------------------------------------------------------
module prefetch_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int FIFO_DEPTH            = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             redirect,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] redirect_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic                             instr_valid,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] instr_pc,
    input  logic                             instr_ready
);

    localparam int AW    = PROGRAM_MEM_ADDR_BITS;
    localparam int DW    = PROGRAM_MEM_DATA_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [AW-1:0]    PC_ONE    = AW'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t           state;
    logic [AW-1:0]    fetch_pc;
    logic [CNT_W-1:0] count;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic [AW-1:0]    pc_mem   [FIFO_DEPTH];
    logic [DW-1:0]    data_mem [FIFO_DEPTH];

    logic             pop;
    logic             push;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] count_after_pop;
    logic [CNT_W-1:0] count_after;
    logic             room_after_pop;
    logic             room_after;

    // A response is only kept when it belongs to a live request; a redirect
    // in the same cycle makes it stale, so it is dropped instead.
    assign pop  = instr_valid & instr_ready;
    assign push = (state == WAIT) & mem_read_ready & ~redirect;

    assign pop_cnt         = pop  ? CNT_ONE : '0;
    assign push_cnt        = push ? CNT_ONE : '0;
    assign count_after_pop = count - pop_cnt;
    assign count_after     = count_after_pop + push_cnt;

    // Issue decisions look at the occupancy after this cycle's pop (and push),
    // which guarantees a returning word always has a free slot.
    assign room_after_pop = (count_after_pop < DEPTH_CNT);
    assign room_after     = (count_after < DEPTH_CNT);

    // Request FSM. Only one read is ever outstanding. A redirect while a read
    // is in flight cannot retract it, so DISCARD holds the request until the
    // memory answers and then throws the answer away. If that answer arrives
    // in the same cycle as a further redirect, the outstanding read is still
    // finished off (valid dropped) rather than re-issued to the old address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            fetch_pc         <= '0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end else if (room_after_pop) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= fetch_pc;
                        state            <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        if (mem_read_ready) begin
                            mem_read_valid <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            state <= DISCARD;
                        end
                    end else if (mem_read_ready) begin
                        fetch_pc <= fetch_pc + PC_ONE;
                        if (room_after) begin
                            mem_read_address <= fetch_pc + PC_ONE;
                        end else begin
                            mem_read_valid <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                    end
                    if (mem_read_ready) begin
                        mem_read_valid <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: begin
                    state          <= IDLE;
                    mem_read_valid <= 1'b0;
                end
            endcase
        end
    end

    // FIFO bookkeeping. A redirect empties the FIFO outright; the pop that
    // may coincide with it has already handed the head to the consumer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count_after;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // FIFO storage; the pushed PC is the address of the request that just
    // completed, which always equals fetch_pc while in WAIT.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= fetch_pc;
            data_mem[wr_ptr] <= mem_read_data;
        end
    end

    // Head presentation: no bypass, and the outputs are forced to zero when
    // the FIFO is empty so the consumer never sees stale entries.
    assign instr_valid = (count != '0);
    assign instruction = instr_valid ? data_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : '0;

endmodule

// File: tb/tb_prefetch_fetcher.sv
// -----------------------------------------------------------------------------
// tb_prefetch_fetcher
//
// Self-checking bench for prefetch_fetcher. A queue-based reference model
// tracks the FIFO contents, the single in-flight request and whether that
// request has been made stale by a redirect. Outputs are compared against it
// on every falling edge; directed sequences additionally pin literal values.
// -----------------------------------------------------------------------------
module tb_prefetch_fetcher;

    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          mem_read_valid;
    logic [AW-1:0] mem_read_address;
    logic          mem_read_ready;
    logic [DW-1:0] mem_read_data;
    logic          instr_valid;
    logic [DW-1:0] instruction;
    logic [AW-1:0] instr_pc;
    logic          instr_ready;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [AW-1:0] qPc[$];
    logic [DW-1:0] qData[$];
    bit            mOut;
    bit            mStale;
    logic [AW-1:0] mReq;
    logic [AW-1:0] mNext;

    prefetch_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(AW),
        .PROGRAM_MEM_DATA_BITS(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .instr_valid(instr_valid),
        .instruction(instruction),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    // Safety net so the run always ends even if something wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Program memory contents: upper byte is the inverted address.
    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        return {~a, a};
    endfunction

    task automatic checkValue(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        qPc.delete();
        qData.delete();
        mOut   = 1'b0;
        mStale = 1'b0;
        mReq   = '0;
        mNext  = '0;
    endtask

    // One clock of the reference behaviour: the consumer pop happens first,
    // then the memory response / redirect / issue decision.
    task automatic modelStep(input bit rd, input logic [AW-1:0] rpc, input bit rdy,
                             input logic [DW-1:0] data, input bit ird);
        if (qPc.size() != 0 && ird) begin
            void'(qPc.pop_front());
            void'(qData.pop_front());
        end
        if (rd) begin
            qPc.delete();
            qData.delete();
            mNext = rpc;
            if (mOut) begin
                if (rdy) begin
                    mOut   = 1'b0;
                    mStale = 1'b0;
                end else begin
                    mStale = 1'b1;
                end
            end
        end else if (mOut && rdy) begin
            if (mStale) begin
                mOut   = 1'b0;
                mStale = 1'b0;
            end else begin
                qPc.push_back(mReq);
                qData.push_back(data);
                if (qPc.size() < DEPTH) begin
                    mReq  = mNext;
                    mNext = mNext + AW'(1);
                end else begin
                    mOut = 1'b0;
                end
            end
        end else if (!mOut) begin
            if (qPc.size() < DEPTH) begin
                mOut  = 1'b1;
                mReq  = mNext;
                mNext = mNext + AW'(1);
            end
        end
    endtask

    // Compare every observable output against the model.
    task automatic checkOutput();
        checkValue("mem_read_valid", 32'(mem_read_valid), 32'(mOut));
        if (mOut) begin
            checkValue("mem_read_address", 32'(mem_read_address), 32'(mReq));
        end
        checkValue("instr_valid", 32'(instr_valid), 32'(qPc.size() != 0));
        if (qPc.size() != 0) begin
            checkValue("instruction", 32'(instruction), 32'(qData[0]));
            checkValue("instr_pc", 32'(instr_pc), 32'(qPc[0]));
        end else begin
            checkValue("instruction_empty", 32'(instruction), 32'h0);
            checkValue("instr_pc_empty", 32'(instr_pc), 32'h0);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, advance the model, then
    // check at the next falling edge. readyMode: 0 never, 1 answer the
    // outstanding request, 2 assert ready regardless.
    task automatic applyStimulus(input bit rd, input logic [AW-1:0] rpc,
                                 input int readyMode, input bit ird);
        bit rdy;
        rdy = (readyMode == 2) || (readyMode == 1 && mOut);
        redirect       = rd;
        redirect_pc    = rpc;
        mem_read_ready = rdy;
        instr_ready    = ird;
        mem_read_data  = (rdy && mOut) ? memWord(mReq) : DW'($urandom);
        modelStep(rd, rpc, rdy, mem_read_data, ird);
        @(negedge clk);
        checkOutput();
    endtask

    task automatic doReset();
        reset          = 1'b1;
        redirect       = 1'b0;
        redirect_pc    = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        instr_ready    = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checkOutput();
    endtask

    initial begin
        // ---------------- reset state and streaming ----------------
        doReset();
        checkValue("reset_valid", 32'(mem_read_valid), 32'h0);
        checkValue("reset_addr", 32'(mem_read_address), 32'h0);
        checkValue("reset_instr_valid", 32'(instr_valid), 32'h0);
        applyStimulus(1'b0, '0, 1, 1'b1);
        checkValue("first_req_valid", 32'(mem_read_valid), 32'h1);
        checkValue("first_req_addr", 32'(mem_read_address), 32'h0);
        applyStimulus(1'b0, '0, 1, 1'b1);
        checkValue("first_instr_pc", 32'(instr_pc), 32'h0);
        checkValue("first_instruction", 32'(instruction), 32'hFF00);
        checkValue("back_to_back_addr", 32'(mem_read_address), 32'h1);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, 1, 1'b1);
        end
        checkValue("stream_instr_pc", 32'(instr_pc), 32'h14);

        // ---------------- stall with consumer blocked ----------------
        doReset();
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, '0, 1, 1'b0);
        end
        checkValue("stall_valid", 32'(mem_read_valid), 32'h0);
        checkValue("stall_instr_valid", 32'(instr_valid), 32'h1);
        checkValue("stall_head_pc", 32'(instr_pc), 32'h0);
        checkValue("stall_head_instr", 32'(instruction), 32'hFF00);
        applyStimulus(1'b0, '0, 1, 1'b1);
        applyStimulus(1'b0, '0, 0, 1'b0);
        checkValue("restart_valid", 32'(mem_read_valid), 32'h1);
        checkValue("restart_addr", 32'(mem_read_address), 32'h4);

        // ---------------- redirect while waiting on address 5 ----------------
        doReset();
        for (int i = 0; i < 20 && !(mOut && mReq == 8'h05); i++) begin
            applyStimulus(1'b0, '0, 1, 1'b1);
        end
        checkValue("wait5_valid", 32'(mem_read_valid), 32'h1);
        checkValue("wait5_addr", 32'(mem_read_address), 32'h5);
        applyStimulus(1'b1, 8'h40, 0, 1'b1);
        applyStimulus(1'b0, '0, 0, 1'b1);
        applyStimulus(1'b0, '0, 0, 1'b1);
        checkValue("discard_hold_valid", 32'(mem_read_valid), 32'h1);
        checkValue("discard_hold_addr", 32'(mem_read_address), 32'h5);
        checkValue("discard_flushed", 32'(instr_valid), 32'h0);
        applyStimulus(1'b0, '0, 1, 1'b1);
        checkValue("discard_drop_valid", 32'(mem_read_valid), 32'h0);
        checkValue("discard_drop_instr", 32'(instr_valid), 32'h0);
        applyStimulus(1'b0, '0, 1, 1'b1);
        checkValue("redirect_req_addr", 32'(mem_read_address), 32'h40);
        applyStimulus(1'b0, '0, 1, 1'b1);
        checkValue("redirect_instr_pc", 32'(instr_pc), 32'h40);
        checkValue("redirect_instr", 32'(instruction), 32'hBF40);

        // ---------------- redirect with ready and pop together ----------------
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1, 1'b0);
        end
        checkValue("pre_redirect_head", 32'(instr_pc), 32'h0);
        applyStimulus(1'b1, 8'h80, 1, 1'b1);
        checkValue("redir_ready_valid", 32'(mem_read_valid), 32'h0);
        checkValue("redir_ready_instr", 32'(instr_valid), 32'h0);
        applyStimulus(1'b0, '0, 1, 1'b0);
        checkValue("redir_ready_next", 32'(mem_read_address), 32'h80);

        // ---------------- PC wrap at 0xFF ----------------
        doReset();
        applyStimulus(1'b1, 8'hFF, 0, 1'b0);
        applyStimulus(1'b0, '0, 1, 1'b0);
        checkValue("wrap_req_ff", 32'(mem_read_address), 32'hFF);
        applyStimulus(1'b0, '0, 1, 1'b0);
        checkValue("wrap_head_ff", 32'(instr_pc), 32'hFF);
        checkValue("wrap_next_addr", 32'(mem_read_address), 32'h0);
        applyStimulus(1'b0, '0, 1, 1'b1);
        checkValue("wrap_head_00", 32'(instr_pc), 32'h0);
        checkValue("wrap_instr_00", 32'(instruction), 32'hFF00);

        // ---------------- asynchronous reset mid-request ----------------
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1, 1'b0);
        end
        #2 reset = 1'b1;
        #1;
        checkValue("async_valid", 32'(mem_read_valid), 32'h0);
        checkValue("async_addr", 32'(mem_read_address), 32'h0);
        checkValue("async_instr_valid", 32'(instr_valid), 32'h0);
        checkValue("async_instr", 32'(instruction), 32'h0);
        checkValue("async_instr_pc", 32'(instr_pc), 32'h0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, '0, 2, 1'b0);
        checkValue("post_reset_valid", 32'(mem_read_valid), 32'h1);
        checkValue("post_reset_addr", 32'(mem_read_address), 32'h0);
        checkValue("post_reset_ignored", 32'(instr_valid), 32'h0);

        // ---------------- randomized traffic ----------------
        doReset();
        for (int i = 0; i < 4000; i++) begin
            bit            rd;
            logic [AW-1:0] rpc;
            int            mode;
            rd   = ($urandom_range(0, 19) == 0);
            rpc  = ($urandom_range(0, 3) == 0) ? (8'hFC + AW'($urandom_range(0, 3)))
                                               : AW'($urandom);
            mode = ($urandom_range(0, 9) < 6) ? 1 : 0;
            applyStimulus(rd, rpc, mode, bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
